pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central hazard/redirect controller for the 5-stage RV64 pipeline. It detects load-use and branch-operand hazards against the decode stage's register reads. It sequences decode-stage redirects (branch/jalr/fence-style) against an in-flight ibus fetch. It issues per-stage stall/flush, drives the PC-select to fetch, and keeps three 64-bit performance counters.

Parameters:
CNT_W, 64, width of each performance counter

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
ra1  in  5  decode source reg 1 (0 = unused)
ra2  in  5  decode source reg 2 (0 = unused)
id_valid  in  1  decode holds a valid instruction
id_br  in  1  decode instruction resolves in D (branch/jalr; uses rs1/rs2 in comparator)
ex_valid  in  1  execute stage valid
ex_dst  in  5  execute stage destination reg
ex_wen  in  1  execute stage writes a register
ex_load  in  1  execute stage is a load
mem_dst  in  5  memory stage destination reg
mem_load  in  1  memory stage is a load (valid-qualified)
redirect_req  in  1  decode PCSel
redirect_pc  in  64  decode pc_address
i_busy  in  1  fetch has an ibus request outstanding
d_busy  in  1  memory stage waiting on dbus
stall_f, stall_d, stall_e, stall_m  out  1 each  hold stage register
flush_d, flush_e, flush_w  out  1 each  load bubble into D/E/W register
pc_sel  out  1  fetch takes pc_next this cycle
pc_next  out  64  redirect target
redirect_pending  out  1  FSM in HOLD
cnt_redirect, cnt_loaduse, cnt_dstall  out  CNT_W each  performance counters

Behaviour:
- Reset (async, resetn=0): FSM=IDLE, held target=0, all counters=0; all outputs 0.
- Hazard terms (combinational; a reg equal to 0 never matches):
  - lu = id_valid & ex_valid & ex_load & (ex_dst==ra1 | ex_dst==ra2).
  - bh = id_valid & id_br & ((ex_valid & ex_wen & ex_dst∈{ra1,ra2}) | (mem_load & mem_dst∈{ra1,ra2})). Branch operands are forwarded only from MEM(non-load)/WB.
  - hz = lu | bh.
- Priority: d_busy > hz > redirect.
  - d_busy=1: stall_f/d/e/m=1, flush_w=1, no redirect accepted, FSM holds state.
  - hz=1 (d_busy=0): stall_f=stall_d=1, flush_e=1. redirect_req is ignored, since its operands are stale.
  - Otherwise, a redirect is accepted when id_valid & redirect_req.
- FSM IDLE:
  - Accept with i_busy=0: pc_sel=1, pc_next=redirect_pc, flush_d=1 in the same cycle; stay IDLE.
  - Accept with i_busy=1: latch redirect_pc, flush_d=1, stall_f=1; go to HOLD.
- FSM HOLD:
  - redirect_pending=1, stall_f=1, pc_sel=0.
  - On the cycle i_busy=0: pc_sel=1, pc_next=latched target, flush_d=1 (discards the stale fetched word); go to IDLE.
  - New redirect_req in HOLD is ignored (D was flushed, so it is never valid).
- pc_sel is never asserted while d_busy=1. If d_busy rises in HOLD, the pending pc_sel waits until d_busy=0 and i_busy=0.
- Counters increment by 1 per cycle, wrap at 2^CNT_W:
  - cnt_redirect: per redirect issue (pc_sel=1).
  - cnt_loaduse: per cycle with hz=1 & d_busy=0.
  - cnt_dstall: per cycle with d_busy=1.
- Latency: a redirect with i_busy=0 has 0 cycles from redirect_req to pc_sel. With i_busy=1, pc_sel fires on the first cycle i_busy is low.
- Reset asserted mid-HOLD: latched target discarded, no pc_sel after release.

Decomposition:
- pipes package gains:
  - pc_ctrl_state_t enum {IDLE, HOLD};
  - hazard_t struct {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}. Ports may be bundled as hazard_t.
- One sub-module, hazard_detect, is natural: purely combinational lu/bh/hz computation. FSM and counters stay in pipe_ctrl.

Test Plan:
- Load-use: ex_load=1, ex_dst=5, ra1=5, id_valid=1 -> stall_f=stall_d=flush_e=1 for 1 cycle, cnt_loaduse=1. Same with ex_dst=0, ra1=0 -> no stall.
- Branch hazard: id_br=1, ex_wen=1, ex_dst=7, ra2=7, redirect_req=1 -> redirect ignored, stall 1 cycle. Next cycle (no hazard) pc_sel=1, pc_next=redirect_pc.
- Redirect idle fetch: redirect_req=1, redirect_pc=0x8000_0100, i_busy=0 -> same cycle pc_sel=1, pc_next=0x8000_0100, flush_d=1, cnt_redirect=1.
- Redirect in-flight: redirect_pc=0x8000_0200, i_busy=1 for 3 cycles -> HOLD 3 cycles (redirect_pending=1, stall_f=1), then pc_sel=1 with 0x8000_0200, flush_d=1, back to IDLE.
- d_busy overlap: in HOLD, d_busy=1 while i_busy falls -> no pc_sel until d_busy=0. All stalls and flush_w=1 meanwhile; cnt_dstall counts those cycles exactly.
- Async reset in HOLD: drop resetn mid-cycle -> outputs 0 immediately, counters 0. After release with i_busy=0, no pc_sel.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/redirect controller.
// Holds the redirect FSM encoding, the per-stage control bundle and register-match helper.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } pc_ctrl_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is never a real producer, so a zero destination can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational detection of load-use and branch-operand hazards
// against the register reads of the instruction in decode.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic       id_br,
  input  logic [4:0] ra1,
  input  logic [4:0] ra2,
  input  logic       ex_valid,
  input  logic [4:0] ex_dst,
  input  logic       ex_wen,
  input  logic       ex_load,
  input  logic [4:0] mem_dst,
  input  logic       mem_load,
  output logic       lu,
  output logic       bh,
  output logic       hz
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_match(ex_dst, ra1) | reg_match(ex_dst, ra2);
  assign mem_hit = reg_match(mem_dst, ra1) | reg_match(mem_dst, ra2);

  // The branch comparator in D only sees forwarded values from MEM (non-load) and WB,
  // so any EX producer or a MEM load is still too young for it.
  assign lu = id_valid & ex_valid & ex_load & ex_hit;
  assign bh = id_valid & id_br & ((ex_valid & ex_wen & ex_hit) | (mem_load & mem_hit));
  assign hz = lu | bh;

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/redirect controller: per-stage stall/flush, fetch PC select
// sequencing against an in-flight ibus request, and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  input  logic             id_valid,
  input  logic             id_br,
  input  logic             ex_valid,
  input  logic [4:0]       ex_dst,
  input  logic             ex_wen,
  input  logic             ex_load,
  input  logic [4:0]       mem_dst,
  input  logic             mem_load,
  input  logic             redirect_req,
  input  logic [63:0]      redirect_pc,
  input  logic             i_busy,
  input  logic             d_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             pc_sel,
  output logic [63:0]      pc_next,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] cnt_redirect,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_dstall
);

  pc_ctrl_state_t state;
  pc_ctrl_state_t next_state;
  logic [63:0]    held_target;
  logic [63:0]    next_target;
  hazard_t        haz;
  logic           sel_c;
  logic [63:0]    next_pc_c;
  logic           lu;
  logic           bh;
  logic           hz;

  hazard_detect u_hazard_detect (
    .id_valid (id_valid),
    .id_br    (id_br),
    .ra1      (ra1),
    .ra2      (ra2),
    .ex_valid (ex_valid),
    .ex_dst   (ex_dst),
    .ex_wen   (ex_wen),
    .ex_load  (ex_load),
    .mem_dst  (mem_dst),
    .mem_load (mem_load),
    .lu       (lu),
    .bh       (bh),
    .hz       (hz)
  );

  // A dbus wait freezes everything, including a pending redirect; a hazard blocks
  // new redirects because the branch operands seen in D are stale.
  always_comb begin
    haz         = '0;
    sel_c       = 1'b0;
    next_pc_c   = '0;
    next_state  = state;
    next_target = held_target;
    if (d_busy) begin
      haz.stall_f = 1'b1;
      haz.stall_d = 1'b1;
      haz.stall_e = 1'b1;
      haz.stall_m = 1'b1;
      haz.flush_w = 1'b1;
    end else begin
      if (hz) begin
        haz.stall_f = 1'b1;
        haz.stall_d = 1'b1;
        haz.flush_e = 1'b1;
      end
      case (state)
        IDLE: begin
          if (!hz && id_valid && redirect_req) begin
            haz.flush_d = 1'b1;
            if (i_busy) begin
              haz.stall_f = 1'b1;
              next_state  = HOLD;
              next_target = redirect_pc;
            end else begin
              sel_c     = 1'b1;
              next_pc_c = redirect_pc;
            end
          end
        end
        HOLD: begin
          haz.stall_f = 1'b1;
          if (!i_busy) begin
            sel_c       = 1'b1;
            next_pc_c   = held_target;
            haz.flush_d = 1'b1;
            next_state  = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even if upstream inputs are active.
  assign stall_f          = resetn & haz.stall_f;
  assign stall_d          = resetn & haz.stall_d;
  assign stall_e          = resetn & haz.stall_e;
  assign stall_m          = resetn & haz.stall_m;
  assign flush_d          = resetn & haz.flush_d;
  assign flush_e          = resetn & haz.flush_e;
  assign flush_w          = resetn & haz.flush_w;
  assign pc_sel           = resetn & sel_c;
  assign pc_next          = resetn ? next_pc_c : '0;
  assign redirect_pending = (state == HOLD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      held_target  <= '0;
      cnt_redirect <= '0;
      cnt_loaduse  <= '0;
      cnt_dstall   <= '0;
    end else begin
      state       <= next_state;
      held_target <= next_target;
      if (sel_c) begin
        cnt_redirect <= cnt_redirect + CNT_W'(1);
      end
      if (hz && !d_busy) begin
        cnt_loaduse <= cnt_loaduse + CNT_W'(1);
      end
      if (d_busy) begin
        cnt_dstall <= cnt_dstall + CNT_W'(1);
      end
    end
  end

endmodule
